// File: rtl/apb_intercon_rr.sv
// APB3 interconnect: round-robin arbitration of MASTER_PORTS requesters onto
// SLAVE_PORTS peripherals with base/mask decode, a default error slave for
// unmapped addresses and an ACCESS-phase timeout.
module apb_intercon_rr #(
  parameter int BUS_WIDTH    = 16,
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS  = 6,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE =
    {16'h8500, 16'h8400, 16'h8300, 16'h8200, 16'h8100, 16'h8000},
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_MASK = {SLAVE_PORTS{16'hFF00}},
  parameter int TIMEOUT      = 255,
  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]        S_PWRITE,
  input  logic [MASTER_PORTS-1:0]        S_PSELx,
  input  logic [MASTER_PORTS-1:0]        S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]        S_PREADY,
  output logic [MASTER_PORTS-1:0]        S_PSLVERR,
  output logic [BUS_WIDTH-1:0]           M_PADDR,
  output logic                           M_PWRITE,
  output logic [SLAVE_PORTS-1:0]         M_PSELx,
  output logic                           M_PENABLE,
  output logic [BUS_WIDTH-1:0]           M_PWDATA,
  input  logic [SLAVE_PORTS*BUS_WIDTH-1:0] M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]         M_PREADY,
  input  logic [SLAVE_PORTS-1:0]         M_PSLVERR,
  output logic [GW-1:0]                  GNT
);
  localparam int SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    gnt_q, gnt_nxt, last_q, last_nxt, pick, cand;
  logic [31:0]      cnt_q, cnt_nxt;
  logic             found, hit, req_g, slv_rdy, tmo;
  logic [SW-1:0]    sidx;
  logic [SLAVE_PORTS-1:0] sel_oh;
  logic [BUS_WIDTH-1:0]   addr_g;
  int               c;

  // S_PENABLE carries no information the slave-side sequencing needs.
  logic unused_pen;
  assign unused_pen = ^S_PENABLE;

  assign addr_g  = S_PADDR[int'(gnt_q)*BUS_WIDTH +: BUS_WIDTH];
  assign req_g   = S_PSELx[gnt_q];
  assign sel_oh  = hit ? (SLAVE_PORTS'(1) << sidx) : '0;
  assign slv_rdy = hit && M_PREADY[sidx];
  assign tmo     = (TIMEOUT != 0) && (cnt_q >= 32'(TIMEOUT - 1));
  assign GNT     = gnt_q;

  // Round-robin pick: first requester after the last-served master, wrapping.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = '0;
    c     = 0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      c    = (int'(last_q) + k) % MASTER_PORTS;
      cand = GW'(c);
      if (!found && S_PSELx[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Address decode of the granted master; lowest matching slave wins.
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int i = SLAVE_PORTS - 1; i >= 0; i--) begin
      if ((addr_g & SLAVE_MASK[i*BUS_WIDTH +: BUS_WIDTH]) == SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH]) begin
        hit  = 1'b1;
        sidx = SW'(i);
      end
    end
  end

  // Next-state and bus outputs; every completion path records last := GNT.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    last_nxt  = last_q;
    cnt_nxt   = cnt_q;
    M_PADDR   = '0;
    M_PWRITE  = 1'b0;
    M_PWDATA  = '0;
    M_PSELx   = '0;
    M_PENABLE = 1'b0;
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = pick;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        M_PADDR  = addr_g;
        M_PWRITE = S_PWRITE[gnt_q];
        M_PWDATA = S_PWDATA[int'(gnt_q)*BUS_WIDTH +: BUS_WIDTH];
        M_PSELx  = sel_oh;
        if (!req_g) begin
          state_nxt = IDLE;
          last_nxt  = gnt_q;
        end else begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        M_PADDR   = addr_g;
        M_PWRITE  = S_PWRITE[gnt_q];
        M_PWDATA  = S_PWDATA[int'(gnt_q)*BUS_WIDTH +: BUS_WIDTH];
        M_PSELx   = sel_oh;
        M_PENABLE = 1'b1;
        if (!req_g) begin
          // master abandoned the transfer: drop it silently
          state_nxt = IDLE;
          last_nxt  = gnt_q;
          cnt_nxt   = '0;
        end else if (slv_rdy || !hit || tmo) begin
          // slave response beats a coincident timeout
          S_PREADY[gnt_q] = 1'b1;
          if (slv_rdy) begin
            S_PRDATA[int'(gnt_q)*BUS_WIDTH +: BUS_WIDTH] = M_PRDATA[int'(sidx)*BUS_WIDTH +: BUS_WIDTH];
            S_PSLVERR[gnt_q] = M_PSLVERR[sidx];
          end else begin
            S_PSLVERR[gnt_q] = 1'b1;
          end
          state_nxt = IDLE;
          last_nxt  = gnt_q;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset leaves master 0 with first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= '0;
      last_q <= GW'(MASTER_PORTS - 1);
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      last_q <= last_nxt;
      cnt_q  <= cnt_nxt;
    end
  end
endmodule
